serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits; legal values 1 or more.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: i_valid  input  1  upstream request valid.
REQ-005 SHALL have port: o_ready  output  1  block can accept a request.
REQ-006 SHALL have port: i_op1  input  WIDTH  minuend, unsigned.
REQ-007 SHALL have port: i_op2  input  WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port: o_valid  output  1  result valid.
REQ-009 SHALL have port: i_ready  input  1  downstream accepts result.
REQ-010 SHALL have port: o_diff  output  WIDTH  (i_op1 - i_op2) mod 2^WIDTH.
REQ-011 SHALL have port: o_bout  output  1  final borrow; 1 iff i_op1 < i_op2 (unsigned).

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL drive o_ready=1 only in IDLE and o_valid=1 only in DONE; both registered, no combinational input-to-output path.
REQ-014 SHALL accept a request on an edge with i_valid=1 and o_ready=1: capture i_op1/i_op2 into shift registers, clear borrow and bit counter, go IDLE->RUN.
REQ-015 SHALL ignore i_valid, i_op1 and i_op2 while o_ready=0; no queuing.
REQ-016 SHALL in RUN process one bit per edge, LSB first: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin); shift d into a result shift register; bout becomes the next bin.
REQ-017 SHALL remain in RUN for exactly WIDTH edges, then go RUN->DONE; o_valid is first high in the cycle after the WIDTH-th edge following the accepting edge.
REQ-018 SHALL load o_diff and o_bout only on the RUN->DONE edge; they stay stable at all other times, including during RUN and backpressure.
REQ-019 SHALL hold DONE, o_valid=1 and outputs unchanged while i_ready=0, for any number of cycles.
REQ-020 SHALL go DONE->IDLE on an edge with o_valid=1 and i_ready=1; o_ready=1 the following cycle; one operation per WIDTH+2 cycles at most.
REQ-021 SHALL ignore i_ready outside DONE.
REQ-022 SHALL handle boundaries: equal operands -> diff 0, bout 0; op2=0 -> diff=op1, bout 0; op1=0, op2=1 -> diff all-ones, bout 1; WIDTH=1 -> single RUN cycle.
REQ-023 SHALL size the bit counter to hold 0..WIDTH without wrap; the counter never exceeds WIDTH.

Reset
REQ-024 SHALL, on any edge with i_rst_n=0, force state IDLE, o_ready=1 (visible after the reset edge), o_valid=0, o_diff=0, o_bout=0, borrow=0, counter=0, shift registers=0.
REQ-025 SHALL, when reset is asserted mid-RUN or in DONE, discard the in-flight operation with no partial result ever presented; the first request after release is processed normally.
REQ-026 SHALL give reset priority over every handshake event on the same edge.

Structure
REQ-027 SHALL place FSM state encodings (IDLE=0, RUN=1, DONE=2, 2 bits) and the default WIDTH constant in the shared package.
REQ-028 SHALL instantiate one sub-module, fs (1-bit full subtractor: a, b, bin -> d, bout), combinational, reusable by other arithmetic blocks.
REQ-029 SHALL keep all sequential logic (FSM, counter, shift registers, borrow flop, output registers) in serial_sub.

Verification
REQ-030 SHALL cover: WIDTH=4; op1=9, op2=3 accepted at edge t -> o_valid first high after edge t+4, o_diff=6, o_bout=0.
REQ-031 SHALL cover: op1=3, op2=9 -> o_diff=4'hA, o_bout=1; op1=0, op2=1 -> 4'hF, 1; op1=15, op2=15 -> 0, 0.
REQ-032 SHALL cover: hold i_ready=0 for 5 cycles in DONE while driving i_valid=1 with op1=1, op2=1 -> o_valid, o_diff and o_bout stable, o_ready=0, the new request is not accepted.
REQ-033 SHALL cover: assert i_rst_n=0 for one edge 2 cycles into RUN -> next cycle o_valid=0, o_ready=1, o_diff=0; then 7-2 -> o_diff=5, o_bout=0.
REQ-034 SHALL cover: 1000 back-to-back random requests with random i_ready -> each result equals (a-b) mod 16 with bout = (a<b), in order, none lost or duplicated.
REQ-035 SHALL cover: WIDTH=1 and WIDTH=8 builds, including 0x00-0x01 -> 0xFF, bout 1, latency equal to WIDTH.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default
// operand width and the bit-counter sizing helper.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must represent 0..width inclusive.
  function automatic int cnt_bits(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// 1-bit full subtractor: d = a - b - bin, with borrow out. Purely combinational
// so it can be shared by any serial or ripple arithmetic block.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor with valid/ready handshakes on both sides.
// One bit per cycle, LSB first; result registers only change on completion.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int             CNT_W = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] d_shift;

  fs u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New difference bit enters at the MSB so the LSB-first result ends aligned.
  assign d_shift = (d_sr_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          state_d  = ST_RUN;
          ready_d  = 1'b0;
          a_sr_d   = i_op1;
          b_sr_d   = i_op2;
          d_sr_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        d_sr_d   = d_shift;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          diff_d  = d_shift;
          bout_d  = fs_bout;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_diff  = diff_q;
  assign o_bout  = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at WIDTH 4, plus WIDTH 8 and 1 builds.
module tb_serial_sub;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  // WIDTH=4 instance
  logic       i_valid, o_ready, o_valid, i_ready, o_bout;
  logic [3:0] i_op1, i_op2, o_diff;
  // WIDTH=8 instance
  logic       v8_valid, r8_ready, o8_valid, i8_ready, o8_bout;
  logic [7:0] i8_op1, i8_op2, o8_diff;
  // WIDTH=1 instance
  logic       v1_valid, r1_ready, o1_valid, i1_ready, o1_bout;
  logic [0:0] i1_op1, i1_op2, o1_diff;

  serial_sub #(.WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op1(i_op1), .i_op2(i_op2), .o_valid(o_valid), .i_ready(i_ready),
    .o_diff(o_diff), .o_bout(o_bout)
  );
  serial_sub #(.WIDTH(8)) dut8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v8_valid), .o_ready(r8_ready),
    .i_op1(i8_op1), .i_op2(i8_op2), .o_valid(o8_valid), .i_ready(i8_ready),
    .o_diff(o8_diff), .o_bout(o8_bout)
  );
  serial_sub #(.WIDTH(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v1_valid), .o_ready(r1_ready),
    .i_op1(i1_op1), .i_op2(i1_op2), .o_valid(o1_valid), .i_ready(i1_ready),
    .o_diff(o1_diff), .o_bout(o1_bout)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op1;
    logic [3:0] op2;
    logic [3:0] diff;
    logic       bout;
  } vec_t;
  vec_t tbl[8];

  logic [4:0] exp_q[$];
  logic       rnd_on = 1'b0;
  int         got = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Full WIDTH=4 transaction: accept, count latency, verify result and handback.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ed, input logic eb, input string name);
    int n;
    logic [3:0] prev_d;
    logic prev_b, held;
    prev_d = o_diff;
    prev_b = o_bout;
    held = 1'b1;
    i_op1 = a; i_op2 = b; i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 20) begin tick(); n++; end
    tick();
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 40) begin
      if (o_diff !== prev_d || o_bout !== prev_b) held = 1'b0;
      tick();
      n++;
    end
    check({name, "_latency"}, n, 4);
    check({name, "_hold_in_run"}, held, 1);
    check({name, "_diff"}, o_diff, ed);
    check({name, "_bout"}, o_bout, eb);
    $display("W4 %s: %0d - %0d -> diff %0h bout %0b", name, a, b, o_diff, o_bout);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({name, "_back_idle"}, {o_ready, o_valid}, 2'b10);
    check({name, "_diff_kept"}, {o_diff, o_bout}, {ed, eb});
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input string name);
    int n;
    i8_op1 = a; i8_op2 = b; v8_valid = 1'b1;
    tick();
    v8_valid = 1'b0;
    n = 0;
    while (!o8_valid && n < 40) begin tick(); n++; end
    check({name, "_latency"}, n, 8);
    check({name, "_result"}, {o8_diff, o8_bout}, {ed, eb});
    $display("W8 %s: %0h - %0h -> diff %0h bout %0b", name, a, b, o8_diff, o8_bout);
    i8_ready = 1'b1;
    tick();
    i8_ready = 1'b0;
  endtask

  task automatic run_op1(input logic a, input logic b, input logic ed,
                         input logic eb, input string name);
    int n;
    i1_op1 = a; i1_op2 = b; v1_valid = 1'b1;
    tick();
    v1_valid = 1'b0;
    n = 0;
    while (!o1_valid && n < 40) begin tick(); n++; end
    check({name, "_latency"}, n, 1);
    check({name, "_result"}, {o1_diff, o1_bout}, {ed, eb});
    $display("W1 %s: %0b - %0b -> diff %0b bout %0b", name, a, b, o1_diff, o1_bout);
    i1_ready = 1'b1;
    tick();
    i1_ready = 1'b0;
  endtask

  // Result monitor for the random phase; a handshake happens on the next edge.
  always @(negedge i_clk) begin
    if (rnd_on && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("rnd_extra_result", 0, 1);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("rnd_result", {o_diff, o_bout}, e);
        $display("RND %0d: diff %0h bout %0b", got, o_diff, o_bout);
      end
      got++;
    end
  end

  initial begin
    tbl[0] = '{4'd9,  4'd3,  4'd6,  1'b0};
    tbl[1] = '{4'd3,  4'd9,  4'hA,  1'b1};
    tbl[2] = '{4'd0,  4'd1,  4'hF,  1'b1};
    tbl[3] = '{4'd15, 4'd15, 4'h0,  1'b0};
    tbl[4] = '{4'd5,  4'd0,  4'h5,  1'b0};
    tbl[5] = '{4'd0,  4'd0,  4'h0,  1'b0};
    tbl[6] = '{4'd8,  4'd7,  4'h1,  1'b0};
    tbl[7] = '{4'd7,  4'd8,  4'hF,  1'b1};

    i_rst_n = 1'b0;
    i_valid = 1'b0; i_ready = 1'b0; i_op1 = '0; i_op2 = '0;
    v8_valid = 1'b0; i8_ready = 1'b0; i8_op1 = '0; i8_op2 = '0;
    v1_valid = 1'b0; i1_ready = 1'b0; i1_op1 = '0; i1_op2 = '0;
    repeat (2) tick();
    check("reset_outputs", {o_ready, o_valid, o_diff, o_bout}, {1'b1, 1'b0, 4'h0, 1'b0});
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      run_op4(tbl[i].op1, tbl[i].op2, tbl[i].diff, tbl[i].bout, $sformatf("vec%0d", i));

    // Backpressure in DONE with a competing request on the input.
    begin
      logic stable;
      stable = 1'b1;
      i_op1 = 4'd9; i_op2 = 4'd3; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      repeat (4) tick();
      check("bp_valid", o_valid, 1);
      i_op1 = 4'd1; i_op2 = 4'd1; i_valid = 1'b1;
      repeat (5) begin
        tick();
        if ({o_valid, o_ready, o_diff, o_bout} !== {1'b1, 1'b0, 4'd6, 1'b0}) stable = 1'b0;
      end
      check("bp_stable", stable, 1);
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      repeat (6) tick();
      check("bp_no_accept", {o_ready, o_valid}, 2'b10);
      $display("BP: held 9 - 3 -> diff %0h bout %0b for 5 cycles", o_diff, o_bout);
    end

    // Reset two cycles into RUN.
    begin
      logic quiet;
      quiet = 1'b1;
      i_op1 = 4'd9; i_op2 = 4'd3; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      repeat (2) tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      check("rst_run_outputs", {o_valid, o_ready, o_diff, o_bout}, {1'b1 ^ 1'b1, 1'b1, 4'h0, 1'b0});
      repeat (8) begin
        tick();
        if (o_valid !== 1'b0) quiet = 1'b0;
      end
      check("rst_run_no_partial", quiet, 1);
      $display("RST: mid-run reset discarded 9 - 3");
      run_op4(4'd7, 4'd2, 4'd5, 1'b0, "post_rst");
    end

    // Reset in DONE wins over a simultaneous handshake.
    i_op1 = 4'd3; i_op2 = 4'd9; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (4) tick();
    check("rst_done_valid", {o_valid, o_diff, o_bout}, {1'b1, 4'hA, 1'b1});
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    i_ready = 1'b0;
    check("rst_done_outputs", {o_valid, o_ready, o_diff, o_bout}, {1'b0, 1'b1, 4'h0, 1'b0});
    $display("RST: reset in DONE cleared result");

    // Back-to-back random requests with random downstream readiness.
    rnd_on = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      logic [3:0] a, b;
      logic acc;
      int n;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      i_op1 = a; i_op2 = b; i_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
        i_ready = 1'($urandom_range(0, 1));
        acc = o_ready;
        tick();
        n++;
      end
      if (acc) exp_q.push_back({4'(a - b), a < b});
      else check("rnd_accept_timeout", 0, 1);
    end
    i_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (got < 1000 && n < 200) begin i_ready = 1'b1; tick(); n++; end
    end
    rnd_on = 1'b0;
    i_ready = 1'b0;
    check("rnd_count", got, 1000);

    run_op8(8'h00, 8'h01, 8'hFF, 1'b1, "w8_zero_minus_one");
    run_op8(8'hC8, 8'h37, 8'h91, 1'b0, "w8_c8_37");
    run_op8(8'h10, 8'h20, 8'hF0, 1'b1, "w8_10_20");

    run_op1(1'b0, 1'b1, 1'b1, 1'b1, "w1_0_1");
    run_op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_1_0");
    run_op1(1'b1, 1'b1, 1'b0, 1'b0, "w1_1_1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
